// File: rtl/mcycle_ctrl_if.sv
// Memory-side bus of the multi-cycle controller.
// The controller is the master; the memory is the slave.
interface mcycle_ctrl_if;
    logic [31:0] instr_in;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel;

    modport master (
        input  instr_in,
        input  mem_ack,
        output mem_req,
        output mem_we,
        output mem_sel
    );

    modport slave (
        output instr_in,
        output mem_ack,
        input  mem_req,
        input  mem_we,
        input  mem_sel
    );
endinterface

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EX/MEM/WB FSM.
// Define MCYCLE_CTRL_ILLEGAL_TRAP_EN to park in S_TRAP on bad opcodes.
module mcycle_ctrl #(
    parameter logic [31:0] PC_INIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    mcycle_ctrl_if.master bus,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [4:0]  ALUctr,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_TRAP = 3'd5;

    logic [2:0]  state;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  dec_alu;
    logic        dec_ok;
    logic        k_r;
    logic        k_j;
    logic        k_lw;
    logic        k_sw;
    logic        k_beq;
    logic [31:0] boff;
    logic [31:0] jtgt;

    assign op    = ir[31:26];
    assign funct = ir[5:0];
    assign boff  = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign jtgt  = {pc[31:28], ir[25:0], 2'b00};

    // Decode the held instruction into ALU op and instruction class
    always_comb begin
        dec_alu = 5'b00000;
        dec_ok  = 1'b1;
        k_r     = 1'b0;
        k_j     = 1'b0;
        k_lw    = 1'b0;
        k_sw    = 1'b0;
        k_beq   = 1'b0;
        case (op)
            6'h00: begin
                k_r = 1'b1;
                case (funct)
                    6'h21: dec_alu = 5'b00000;
                    6'h23: dec_alu = 5'b00001;
                    6'h2A: dec_alu = 5'b00010;
                    6'h24: dec_alu = 5'b00011;
                    6'h27: dec_alu = 5'b00100;
                    6'h25: dec_alu = 5'b00101;
                    6'h26: dec_alu = 5'b00110;
                    6'h00: dec_alu = 5'b00111;
                    6'h02: dec_alu = 5'b01000;
                    6'h2B: dec_alu = 5'b01001;
                    6'h04: dec_alu = 5'b01100;
                    6'h03: dec_alu = 5'b01101;
                    6'h07: dec_alu = 5'b01110;
                    6'h06: dec_alu = 5'b01111;
                    default: dec_ok = 1'b0;
                endcase
            end
            6'h02: k_j = 1'b1;
            6'h04: begin
                k_beq   = 1'b1;
                dec_alu = 5'b00001;
            end
            6'h09: dec_alu = 5'b10000;
            6'h0A: dec_alu = 5'b10001;
            6'h0B: dec_alu = 5'b10010;
            6'h0C: dec_alu = 5'b10011;
            6'h0D: dec_alu = 5'b10100;
            6'h0E: dec_alu = 5'b10101;
            6'h23: begin
                k_lw    = 1'b1;
                dec_alu = 5'b10000;
            end
            6'h2B: begin
                k_sw    = 1'b1;
                dec_alu = 5'b10000;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // FSM, pc, ir and ALUctr registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IF;
            pc     <= PC_INIT;
            ir     <= 32'h0;
            ALUctr <= 5'b00000;
        end else begin
            case (state)
                S_IF: begin
                    if (bus.mem_ack) begin
                        ir    <= bus.instr_in;
                        pc    <= pc + 32'd4;
                        state <= S_ID;
                    end
                end
                S_ID: begin
                    ALUctr <= dec_alu;
                    unique case (1'b1)
                        k_j: begin
                            pc    <= jtgt;
                            state <= S_IF;
                        end
                        !dec_ok: begin
`ifdef MCYCLE_CTRL_ILLEGAL_TRAP_EN
                            state <= S_TRAP;
`else
                            state <= S_IF;
`endif
                        end
                        default: state <= S_EX;
                    endcase
                end
                S_EX: begin
                    if (k_beq) begin
                        if (zero) pc <= pc + boff;
                        state <= S_IF;
                    end else if (k_lw || k_sw) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ack) state <= k_lw ? S_WB : S_IF;
                end
                S_WB:   state <= S_IF;
                S_TRAP: state <= S_TRAP;
                default: state <= S_IF;
            endcase
        end
    end

`ifdef MCYCLE_CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) illegal <= 1'b0;
        else if (state == S_ID && !dec_ok) illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    // Strobes are forced low while reset is held
    assign bus.mem_req = rst_n && (state == S_IF || state == S_MEM);
    assign bus.mem_sel = rst_n && (state == S_MEM);
    assign bus.mem_we  = rst_n && (state == S_MEM) && k_sw;
    assign reg_we      = rst_n && (state == S_WB);
    assign reg_dst     = rst_n && (state == S_WB) && k_r;
    assign mem_to_reg  = rst_n && (state == S_WB) && k_lw;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Bench for mcycle_ctrl: transaction-level model expands each
// instruction into an expected per-cycle trace, checked every cycle.
module tb_mcycle_ctrl;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3;
    localparam int K_BEQ = 4, K_J = 5, K_BAD = 6;

    logic        clk;
    logic        rst_n;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  ALUctr;
    logic        reg_we;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        illegal;

    mcycle_ctrl_if bus ();

    mcycle_ctrl #(.PC_INIT(32'h0000_3000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .zero       (zero),
        .pc         (pc),
        .ir         (ir),
        .ALUctr     (ALUctr),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        first;
        logic        ack;
        logic        zero;
        logic [31:0] din;
        logic        req, we, sel, rwe, rdst, m2r, ill;
        logic        alu_ok;
        logic [4:0]  alu;
        logic [31:0] pc, ir;
    } cyc_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    cyc_t plan[$];
    cyc_t exp_q[$];
    lit_t lit_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int req_cnt = 0;
    int rwe_at  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [4:0]  m_alu;
    logic        m_alu_ok;

    logic [5:0] r_fn [14] = '{6'h21, 6'h23, 6'h2A, 6'h24, 6'h27, 6'h25,
                              6'h26, 6'h00, 6'h02, 6'h2B, 6'h04, 6'h03,
                              6'h07, 6'h06};
    logic [4:0] r_code [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
                                5'd6, 5'd7, 5'd8, 5'd9, 5'd12, 5'd13,
                                5'd14, 5'd15};
    logic [5:0] i_op [6] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
    logic [4:0] i_code [6] = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};

    function automatic void lit(string n, logic [31:0] a, logic [31:0] e);
        lit_t l;
        l.name = n;
        l.act  = a;
        l.exp  = e;
        lit_q.push_back(l);
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, a, e, $time);
        end
    endtask

    function automatic void classify(input logic [31:0] ins,
                                     output int kind,
                                     output logic [4:0] code);
        kind = K_BAD;
        code = 5'd0;
        if (ins[31:26] == 6'h00) begin
            for (int i = 0; i < 14; i++)
                if (ins[5:0] == r_fn[i]) begin
                    kind = K_R;
                    code = r_code[i];
                end
        end else if (ins[31:26] == 6'h02) begin
            kind = K_J;
        end else if (ins[31:26] == 6'h04) begin
            kind = K_BEQ;
            code = 5'd1;
        end else if (ins[31:26] == 6'h23) begin
            kind = K_LW;
            code = 5'd16;
        end else if (ins[31:26] == 6'h2B) begin
            kind = K_SW;
            code = 5'd16;
        end else begin
            for (int i = 0; i < 6; i++)
                if (ins[31:26] == i_op[i]) begin
                    kind = K_I;
                    code = i_code[i];
                end
        end
    endfunction

    function automatic cyc_t mk(input bit noise);
        cyc_t e;
        e.first  = 1'b0;
        e.ack    = noise;
        e.zero   = noise;
        e.din    = 32'hDEAD_BEEF;
        e.req    = 1'b0;
        e.we     = 1'b0;
        e.sel    = 1'b0;
        e.rwe    = 1'b0;
        e.rdst   = 1'b0;
        e.m2r    = 1'b0;
        e.ill    = 1'b0;
        e.alu_ok = m_alu_ok;
        e.alu    = m_alu;
        e.pc     = m_pc;
        e.ir     = m_ir;
        return e;
    endfunction

    function automatic logic [31:0] rins(input logic [5:0] fn);
        return {6'd0, 5'd4, 5'd5, 5'd6, 5'd2, fn};
    endfunction

    function automatic logic [31:0] iins(input logic [5:0] opc);
        return {opc, 5'd1, 5'd2, 16'h8004};
    endfunction

    // fw/mw: wait cycles before fetch/data ack; noise drives ack and
    // zero high in cycles where they must be ignored
    task automatic run(input logic [31:0] ins, input int fw, input int mw,
                       input bit z, input bit noise, input int abort_at);
        cyc_t e;
        int kind;
        logic [4:0] code;
        plan.delete();
        classify(ins, kind, code);
        for (int i = 0; i <= fw; i++) begin
            e = mk(1'b0);
            e.first = (i == 0);
            e.req = 1'b1;
            e.ack = (i == fw);
            e.din = (i == fw) ? ins : 32'hBAD0_BAD0;
            plan.push_back(e);
        end
        m_ir = ins;
        m_pc = m_pc + 32'd4;
        plan.push_back(mk(noise));
        if (kind == K_J) begin
            m_alu_ok = 1'b0;
            m_pc = {m_pc[31:28], ins[25:0], 2'b00};
        end else if (kind == K_BAD) begin
            m_alu_ok = 1'b0;
`ifdef MCYCLE_CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++) begin
                e = mk(noise);
                e.ill = 1'b1;
                plan.push_back(e);
            end
`endif
        end else begin
            m_alu = code;
            m_alu_ok = 1'b1;
            e = mk(noise);
            e.zero = z;
            plan.push_back(e);
            if (kind == K_BEQ) begin
                if (z) m_pc = m_pc + {{14{ins[15]}}, ins[15:0], 2'b00};
            end else begin
                if (kind == K_LW || kind == K_SW)
                    for (int i = 0; i <= mw; i++) begin
                        e = mk(1'b0);
                        e.req = 1'b1;
                        e.sel = 1'b1;
                        e.we  = (kind == K_SW);
                        e.ack = (i == mw);
                        e.din = 32'h5A5A_A5A5;
                        plan.push_back(e);
                    end
                if (kind != K_SW) begin
                    e = mk(noise);
                    e.rwe  = 1'b1;
                    e.rdst = (kind == K_R);
                    e.m2r  = (kind == K_LW);
                    plan.push_back(e);
                end
            end
        end
        for (int k = 0; k < plan.size(); k++) begin
            if (k == abort_at) break;
            bus.mem_ack  = plan[k].ack;
            zero         = plan[k].zero;
            bus.instr_in = plan[k].din;
            exp_q.push_back(plan[k]);
            @(posedge clk);
            #1;
        end
        bus.mem_ack = 1'b0;
        zero = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ack = 1'b0;
        zero = 1'b0;
        #1;
        lit("rst_req_now", bus.mem_req, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        lit("rst_pc", pc, 32'h0000_3000);
        lit("rst_ir", ir, 0);
        lit("rst_alu", ALUctr, 0);
        lit("rst_ill", illegal, 0);
        lit("rst_req", bus.mem_req, 0);
        lit("rst_we", bus.mem_we, 0);
        lit("rst_rwe", reg_we, 0);
        lit("rst_dst", reg_dst, 0);
        lit("rst_m2r", mem_to_reg, 0);
        rst_n = 1'b1;
        m_pc = 32'h0000_3000;
        m_ir = 32'h0;
        m_alu = 5'd0;
        m_alu_ok = 1'b1;
    endtask

    // Single compare process: literal checks plus per-cycle trace
    initial begin : cmp
        cyc_t ce;
        lit_t l;
        forever begin
            @(negedge clk);
            while (lit_q.size() > 0) begin
                l = lit_q.pop_front();
                chk(l.name, l.act, l.exp);
            end
            if (exp_q.size() > 0) begin
                ce = exp_q.pop_front();
                if (ce.first) begin
                    cyc_cnt = 0;
                    req_cnt = 0;
                    rwe_at  = 0;
                end
                cyc_cnt++;
                if (bus.mem_req) req_cnt++;
                if (reg_we) rwe_at = cyc_cnt;
                chk("mem_req", bus.mem_req, ce.req);
                chk("mem_we", bus.mem_we, ce.we);
                chk("mem_sel", bus.mem_sel, ce.sel);
                chk("reg_we", reg_we, ce.rwe);
                chk("reg_dst", reg_dst, ce.rdst);
                chk("mem_to_reg", mem_to_reg, ce.m2r);
                chk("illegal", illegal, ce.ill);
                chk("pc", pc, ce.pc);
                chk("ir", ir, ce.ir);
                if (ce.alu_ok) chk("ALUctr", ALUctr, ce.alu);
            end
        end
    end

    initial begin : stim
        bus.instr_in = 32'h0;
        bus.mem_ack = 1'b0;
        zero = 1'b0;
        m_pc = 32'h0;
        m_ir = 32'h0;
        m_alu = 5'd0;
        m_alu_ok = 1'b0;
        do_reset();

        run(32'h0109_5021, 0, 0, 1'b0, 1'b0, -1);
        lit("addu_len", plan.size(), 4);
        lit("addu_wecyc", rwe_at, 4);
        lit("addu_pc", pc, 32'h0000_3004);
        lit("addu_alu", ALUctr, 5'b00000);

        run(32'h3508_00FF, 3, 0, 1'b0, 1'b0, -1);
        lit("ori_len", plan.size(), 7);
        lit("ori_reqcyc", req_cnt, 4);
        lit("ori_alu", ALUctr, 5'b10100);

        run(32'h0, 0, 0, 1'b0, 1'b1, -1);
        for (int i = 0; i < 14; i++)
            run(rins(r_fn[i]), i % 3, 0, 1'b0, (i % 2) == 1, -1);
        for (int i = 0; i < 6; i++)
            run(iins(i_op[i]), i % 2, 0, 1'b0, 1'b1, -1);

        run(iins(6'h23), 0, 0, 1'b0, 1'b0, -1);
        lit("lw_len", plan.size(), 5);
        run(iins(6'h2B), 0, 0, 1'b0, 1'b0, -1);
        lit("sw_len", plan.size(), 4);
        run(iins(6'h23), 1, 2, 1'b0, 1'b1, -1);
        run(iins(6'h2B), 2, 3, 1'b0, 1'b1, -1);

        run({6'h02, 26'h000_0C40}, 0, 0, 1'b0, 1'b1, -1);
        lit("j_len", plan.size(), 2);
        lit("j_pc", pc, 32'h0000_3100);

        do_reset();
        run(32'h1000_FFFF, 0, 0, 1'b1, 1'b0, -1);
        lit("beq_len", plan.size(), 3);
        lit("beq_t_pc", pc, 32'h0000_3000);
        run(32'h1000_FFFF, 1, 0, 1'b0, 1'b1, -1);
        lit("beq_nt_pc", pc, 32'h0000_3004);

        run(iins(6'h23), 0, 3, 1'b0, 1'b0, 4);
        do_reset();
        run(32'h0109_5021, 1, 0, 1'b0, 1'b0, -1);

        do_reset();
`ifdef MCYCLE_CTRL_ILLEGAL_TRAP_EN
        run(32'hFC00_0000, 0, 0, 1'b0, 1'b1, -1);
        lit("trap_ill", illegal, 1);
        lit("trap_req", bus.mem_req, 0);
        do_reset();
        run(32'h0109_5021, 0, 0, 1'b0, 1'b0, -1);
`else
        run(32'hFC00_0000, 0, 0, 1'b0, 1'b1, -1);
        lit("bad_op_pc", pc, 32'h0000_3004);
        lit("bad_op_ill", illegal, 0);
        run(32'h0000_003F, 0, 0, 1'b0, 1'b1, -1);
        lit("bad_fn_pc", pc, 32'h0000_3008);
`endif

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
